// File: rtl/sm_para_sched_pkg.sv
// Shared definitions for the two-requester FSM scheduler: state encodings,
// the idle drive pattern, the error counter width and a requester mask helper.
package sm_para_sched_pkg;

    typedef enum logic [1:0] {
        SM_IDLE    = 2'b00,
        SM_DRIVE   = 2'b01,
        SM_RECOVER = 2'b10
    } sm_state_t;

    // Pattern applied to the FSM {i1,i2} whenever no command is being driven
    localparam logic [1:0] SM_IDLE_PAT = 2'b00;

    // Width of the saturating error-cycle counter
    localparam int ERR_CNT_W = 8;

    // One-hot mask for requester index 0/1
    function automatic logic [1:0] rq_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sm_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester not granted last wins;
// a lone requester always wins. Purely combinational; the caller owns the pointer.
module sm_rr_arb2
    import sm_para_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       win
);

    // Pick the winner index and its one-hot grant
    always_comb begin
        win = 1'b0;
        gnt = 2'b00;
        unique case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~ptr;
            default: win = 1'b0;
        endcase
        if (req != 2'b00) begin
            gnt = rq_onehot(win);
        end
    end

endmodule

// File: rtl/sm_para_sched.sv
// Scheduler sharing one sm_para_1_var FSM between two command sources.
// Accepts {i1,i2} patterns with hold lengths, grants round-robin, drives the
// FSM for the requested cycles, aborts on FSM err and enforces a recovery gap.
module sm_para_sched
    import sm_para_sched_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int REC_CYC = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [1:0]           req,
    input  logic [1:0]           cmd0,
    input  logic [1:0]           cmd1,
    input  logic [LEN_W-1:0]     len0,
    input  logic [LEN_W-1:0]     len1,
    output logic [1:0]           ack,
    output logic [1:0]           done,
    output logic [1:0]           fail,
    output logic                 busy,
    output logic                 fsm_i1,
    output logic                 fsm_i2,
    input  logic                 fsm_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Counter must hold both the longest hold length and the recovery length
    localparam int CNT_W = (LEN_W > 8) ? LEN_W : 8;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_REC = CNT_W'(REC_CYC);

    sm_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;   // round-robin pointer, also owner of the active command
    logic [1:0]       gnt;
    logic             win;
    logic [1:0]       sel_cmd;
    logic [LEN_W-1:0] sel_len;
    logic [CNT_W-1:0] hold_len;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sm_rr_arb2 u_arb (
        .req (req),
        .ptr (last_gnt),
        .gnt (gnt),
        .win (win)
    );

    // Select the winner's command and hold length; a zero length means one cycle
    always_comb begin
        sel_cmd  = win ? cmd1 : cmd0;
        sel_len  = win ? len1 : len0;
        hold_len = (sel_len == '0) ? CNT_ONE : CNT_W'(sel_len);
    end

    // busy is a decode of the state register only, so no input reaches it combinationally
    assign busy = (state != SM_IDLE);

    // Scheduler FSM: accept, drive for L cycles, abort into recovery on err
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state            <= SM_IDLE;
            cnt              <= '0;
            last_gnt         <= 1'b1;
            ack              <= 2'b00;
            done             <= 2'b00;
            fail             <= 2'b00;
            {fsm_i1, fsm_i2} <= SM_IDLE_PAT;
        end else begin
            ack  <= 2'b00;
            done <= 2'b00;
            fail <= 2'b00;
            case (state)
                SM_IDLE: begin
                    {fsm_i1, fsm_i2} <= SM_IDLE_PAT;
                    if (req != 2'b00) begin
                        ack              <= gnt;
                        last_gnt         <= win;
                        {fsm_i1, fsm_i2} <= sel_cmd;
                        cnt              <= hold_len;
                        state            <= SM_DRIVE;
                    end
                end
                SM_DRIVE: begin
                    if (fsm_err) begin
                        // err wins over completion, even on the final drive cycle
                        fail             <= rq_onehot(last_gnt);
                        {fsm_i1, fsm_i2} <= SM_IDLE_PAT;
                        cnt              <= CNT_REC;
                        state            <= SM_RECOVER;
                    end else if (cnt == CNT_ONE) begin
                        done             <= rq_onehot(last_gnt);
                        {fsm_i1, fsm_i2} <= SM_IDLE_PAT;
                        cnt              <= '0;
                        state            <= SM_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                SM_RECOVER: begin
                    {fsm_i1, fsm_i2} <= SM_IDLE_PAT;
                    if (cnt == CNT_ONE) begin
                        cnt   <= '0;
                        state <= SM_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    {fsm_i1, fsm_i2} <= SM_IDLE_PAT;
                    cnt              <= '0;
                    state            <= SM_IDLE;
                end
            endcase
        end
    end

    // Count every cycle in which the FSM reports err, saturating at all-ones
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_cnt <= '0;
        end else if (fsm_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule
